// File: rtl/uart_rx_sipo_if.sv
// Receive-side UART bundle: serial line in, parallel byte and status strobes out.
interface uart_rx_sipo_if;
  logic       rx_serial;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  // Line driver / byte consumer side
  modport master (
    output rx_serial,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  busy
  );

  // Receiver side
  modport slave (
    input  rx_serial,
    output data_out,
    output data_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_sipo.sv
// RS232 receiver: synchronises the serial line, finds the start bit, samples eight
// data bits at mid-bit, checks the stop bit and presents each good byte in parallel.
module uart_rx_sipo #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          MSB_FIRST    = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_sipo_if.slave  rx_if
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t        state, state_n;
  logic          sync1, rx_sync;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    data_q;
  logic          valid_q, err_q;
  logic          half_done, bit_done;

  assign half_done = (cnt == CW'(HALF - 1));
  assign bit_done  = (cnt == CW'(CLKS_PER_BIT - 1));

  // Two-flop synchroniser; idle line level is 1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync1   <= rx_if.rx_serial;
      rx_sync <= sync1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (!rx_sync) state_n = S_START;
      S_START:     if (half_done) state_n = rx_sync ? S_IDLE : S_DATA;
      S_DATA:      if (bit_done && bit_idx == 3'd7) state_n = S_STOP;
      S_STOP:      if (bit_done) state_n = rx_sync ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_sync) state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // Bit-period counter: restarts on every state change and on each data-bit boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_n != state || bit_done ||
                 state == S_IDLE || state == S_WAIT_HIGH) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Data-bit index and shift register; the 3-bit index wraps to 0 after the 8th bit
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= '0;
      shift   <= '0;
    end else if (state == S_START && state_n == S_DATA) begin
      bit_idx <= '0;
    end else if (state == S_DATA && bit_done) begin
      bit_idx <= bit_idx + 3'd1;
      if (MSB_FIRST) shift <= {shift[6:0], rx_sync};
      else           shift <= {rx_sync, shift[7:1]};
    end
  end

  // Stop-bit decision: registered one-cycle strobes, byte updated only on a good frame
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (state == S_STOP && bit_done) begin
        if (rx_sync) begin
          data_q  <= shift;
          valid_q <= 1'b1;
        end else begin
          err_q   <= 1'b1;
        end
      end
    end
  end

  // Outputs: busy decoded from the state register
  always_comb begin
    rx_if.busy       = (state != S_IDLE);
    rx_if.data_out   = data_q;
    rx_if.data_valid = valid_q;
    rx_if.frame_err  = err_q;
  end

endmodule
